vnu_msg_serializer: RTL and testbench
=====================================

Name: vnu_msg_serializer

Overview:
- Downstream stage of the shuffled VNU in the DG-LDPC shuffled decoder.
- Each cycle the VNU produces 4 extrinsic V2C messages plus 1 APP value, all 10-bit sign-magnitude. This block registers that bundle and saturates the extrinsics to the 6-bit sign-magnitude message format.
- It then streams the 4 messages one per cycle toward the CNU/message memory over a valid/ready handshake, and emits the hard decision and APP for the variable node.

Parameters:
- DW_IN, 10, width of VNU output words (SM, sign = MSB).
- DW_OUT, 6, width of V2C message words (SM, sign = MSB).
- N_EDGE, 4, number of extrinsic messages per variable node (VN degree).
- IDXW, 10, width of the variable-node index tag.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  VNU bundle valid.
- o_ready  output  1  block can accept a bundle this cycle.
- i_data  input  [0:N_EDGE][DW_IN-1:0]  entries 0..N_EDGE-1 are extrinsic messages, entry N_EDGE is the APP; all SM.
- i_vn_idx  input  IDXW  variable-node index accompanying the bundle.
- o_valid  output  1  serialized message valid.
- i_ready  input  1  downstream accepts the message.
- o_msg  output  DW_OUT  saturated SM V2C message.
- o_edge  output  $clog2(N_EDGE)  edge number of o_msg (0..N_EDGE-1).
- o_last  output  1  high with edge N_EDGE-1.
- o_vn_idx  output  IDXW  index of the bundle currently being streamed.
- o_hd_valid  output  1  one-cycle pulse carrying the hard decision.
- o_hd  output  1  hard decision bit.
- o_app  output  DW_IN  registered APP (SM).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: o_valid=0, o_msg=0, o_edge=0, o_last=0, o_vn_idx=0, o_hd_valid=0, o_hd=0, o_app=0, o_ready=1, FSM=IDLE, beat counter=0.
- FSM state IDLE:
  - o_ready=1.
  - On i_valid&&o_ready: latch saturated extrinsics, APP and index; go to SEND with cnt=0.
- FSM state SEND:
  - o_valid=1; o_msg=buf[cnt], o_edge=cnt, o_last=(cnt==N_EDGE-1).
  - On i_valid fire of a non-last beat (o_valid&&i_ready): cnt++.
  - On the last beat firing: if i_valid then reload from the new bundle and stay in SEND with cnt=0; else go to IDLE.
- o_ready is combinational: (state==IDLE) || (o_valid&&i_ready&&o_last). This gives back-to-back bundles with no bubble: N_EDGE cycles per VN when i_ready is stuck at 1.
- Stall rule: while o_valid&&!i_ready, o_msg, o_edge, o_last and o_vn_idx hold stable.
- Latency: capture cycle T gives the first o_valid at T+1.
- Hard decision and APP:
  - o_hd_valid pulses at T+1 with o_hd = APP sign bit (1 = negative LLR, decoded bit 1).
  - o_app is updated at T+1 and held until the next capture.
- Saturation rule (per extrinsic):
  - sign_out = sign_in.
  - mag_out = min(mag_in, 2^(DW_OUT-1)-1) = 31.
  - Negative zero (sign=1, mag=0) is output as +0.
  - APP is not saturated.
- Reset mid-stream: all state is cleared immediately, the partial bundle is dropped and no o_last is issued.
- i_valid while o_ready=0: ignored (upstream holds the bundle).

Optional Feature:
- Macro: VNU_SAT_CNT_EN.
- Defined:
  - Adds output o_sat_cnt[15:0], reset to 0.
  - Increments by the number of extrinsics clipped at each capture (0..N_EDGE).
  - Sticks at 16'hFFFF.
  - Adds input i_sat_clr (synchronous clear, priority over increment).
- Undefined: the port, the counter and i_sat_clr are absent; all other behaviour is identical.

Decomposition:
- Package vnu_pkg:
  - localparams VNU_DW_IN=10, VNU_DW_OUT=6, VNU_N_EDGE=4.
  - typedefs vnu_word_t (logic [9:0]) and v2c_msg_t (logic [5:0]).
  - FSM enum ser_state_t {IDLE, SEND}.
- Sub-module sm_saturate #(DW_IN, DW_OUT):
  - Combinational SM narrowing with a clip flag output.
  - Instantiated N_EDGE times; the clip flags feed the optional counter.

Test Plan:
1. Single bundle, i_ready=1: extrinsics 10'h005, 10'h245, 10'h200, 10'h01F; APP 10'h3FF -> o_msg 6'h05, 6'h3F, 6'h00, 6'h1F on edges 0..3 at T+1..T+4; o_last at T+4; o_hd=1 pulse at T+1; o_app=10'h3FF.
2. Back-to-back: i_valid held for 3 bundles, i_ready=1 -> 12 consecutive o_valid cycles; o_ready high only on each o_last cycle; o_vn_idx steps 0,1,2 at bundle boundaries.
3. Backpressure: i_ready=0 on cycles T+2..T+4 -> edge 1 held stable for 3 cycles, no duplication or loss; o_last appears at T+7.
4. Reset mid-stream: assert rst_n=0 during edge 2 -> o_valid=0 and o_ready=1 immediately; after release, the next bundle streams from edge 0.
5. Saturation boundary: magnitudes 31, 32, 511 both signs (10'h01F, 10'h020, 10'h1FF, 10'h21F, 10'h220, 10'h3FF) -> 6'h1F, 6'h1F, 6'h1F, 6'h3F, 6'h3F, 6'h3F.
6. VNU_SAT_CNT_EN: bundle from scenario 1 -> o_sat_cnt=1; preload 16'hFFFE, then two bundles with 4 clips each -> 16'hFFFF; i_sat_clr -> 0.

Source files
------------

// File: rtl/vnu_pkg.sv
// Shared types and constants for the shuffled-VNU message serializer.
package vnu_pkg;

  localparam int unsigned VNU_DW_IN  = 10;
  localparam int unsigned VNU_DW_OUT = 6;
  localparam int unsigned VNU_N_EDGE = 4;

  typedef logic [VNU_DW_IN-1:0]  vnu_word_t;
  typedef logic [VNU_DW_OUT-1:0] v2c_msg_t;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } ser_state_t;

endpackage

// File: rtl/sm_saturate.sv
// Sign-magnitude narrowing: clamps the magnitude to the largest value the
// output width can carry and folds negative zero to +0.
module sm_saturate #(
  parameter int unsigned DW_IN  = 10,
  parameter int unsigned DW_OUT = 6
) (
  input  logic [DW_IN-1:0]  data_i,
  output logic [DW_OUT-1:0] data_o,
  output logic              clip_o
);

  localparam logic [DW_IN-2:0] MaxMag = (DW_IN-1)'((1 << (DW_OUT - 1)) - 1);

  logic [DW_IN-2:0]  mag_in;
  logic [DW_OUT-2:0] mag_out;

  // Clamp magnitude, keep sign unless the result is zero.
  always_comb begin
    mag_in  = data_i[DW_IN-2:0];
    clip_o  = (mag_in > MaxMag);
    mag_out = clip_o ? MaxMag[DW_OUT-2:0] : mag_in[DW_OUT-2:0];
    data_o  = {data_i[DW_IN-1] & (|mag_out), mag_out};
  end

endmodule

// File: rtl/vnu_msg_serializer.sv
// Registers one VNU bundle (N_EDGE extrinsics + APP), saturates the
// extrinsics to V2C width and streams them one per cycle over valid/ready.
// The hard decision and APP are emitted one cycle after capture.
// Optional saturation statistics counter: define VNU_SAT_CNT_EN.
// N_EDGE must be at least 2.
module vnu_msg_serializer import vnu_pkg::*; #(
  parameter int unsigned DW_IN  = VNU_DW_IN,
  parameter int unsigned DW_OUT = VNU_DW_OUT,
  parameter int unsigned N_EDGE = VNU_N_EDGE,
  parameter int unsigned IDXW   = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [0:N_EDGE][DW_IN-1:0]     i_data,
  input  logic [IDXW-1:0]                i_vn_idx,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [DW_OUT-1:0]              o_msg,
  output logic [$clog2(N_EDGE)-1:0]      o_edge,
  output logic                           o_last,
  output logic [IDXW-1:0]                o_vn_idx,
  output logic                           o_hd_valid,
  output logic                           o_hd,
  output logic [DW_IN-1:0]               o_app
`ifdef VNU_SAT_CNT_EN
  ,
  input  logic                           i_sat_clr,
  output logic [15:0]                    o_sat_cnt
`endif
);

  localparam int unsigned   EW       = $clog2(N_EDGE);
  localparam logic [EW-1:0] LastEdge = EW'(N_EDGE - 1);

  logic [N_EDGE-1:0][DW_OUT-1:0] sat_msg;
  logic [N_EDGE-1:0]             clip;

  ser_state_t                    state_q;
  logic [EW-1:0]                 cnt_q;
  logic [EW-1:0]                 cnt_inc;
  logic [N_EDGE-1:0][DW_OUT-1:0] msg_buf_q;

  logic fire;
  logic last_fire;
  logic capture;

  for (genvar g = 0; g < N_EDGE; g++) begin : g_sat
    sm_saturate #(
      .DW_IN (DW_IN),
      .DW_OUT(DW_OUT)
    ) u_sat (
      .data_i(i_data[g]),
      .data_o(sat_msg[g]),
      .clip_o(clip[g])
    );
  end

  // Handshake decode; a new bundle may land on the same edge the last beat leaves.
  always_comb begin
    fire      = o_valid & i_ready;
    last_fire = fire & o_last;
    o_ready   = (state_q == IDLE) | last_fire;
    capture   = i_valid & o_ready;
    cnt_inc   = cnt_q + EW'(1);
    o_edge    = cnt_q;
  end

  // Serializer FSM with registered stream, hard-decision and APP outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      msg_buf_q  <= '0;
      o_valid    <= 1'b0;
      o_msg      <= '0;
      o_last     <= 1'b0;
      o_vn_idx   <= '0;
      o_hd_valid <= 1'b0;
      o_hd       <= 1'b0;
      o_app      <= '0;
    end else begin
      o_hd_valid <= 1'b0;
      if (capture) begin
        state_q    <= SEND;
        cnt_q      <= '0;
        msg_buf_q  <= sat_msg;
        o_valid    <= 1'b1;
        o_msg      <= sat_msg[0];
        o_last     <= (LastEdge == '0);
        o_vn_idx   <= i_vn_idx;
        o_hd_valid <= 1'b1;
        o_hd       <= i_data[N_EDGE][DW_IN-1];
        o_app      <= i_data[N_EDGE];
      end else if (last_fire) begin
        state_q <= IDLE;
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end else if (fire) begin
        cnt_q  <= cnt_inc;
        o_msg  <= msg_buf_q[cnt_inc];
        o_last <= (cnt_inc == LastEdge);
      end
    end
  end

`ifdef VNU_SAT_CNT_EN
  localparam int unsigned CW = $clog2(N_EDGE + 1);

  logic [15:0]   sat_cnt_q;
  logic [CW-1:0] clip_num;
  logic [16:0]   sat_sum;

  // Number of extrinsics clipped in the bundle on the input.
  always_comb begin
    clip_num = '0;
    for (int k = 0; k < N_EDGE; k++) begin
      clip_num = clip_num + CW'(clip[k]);
    end
    sat_sum = {1'b0, sat_cnt_q} + 17'(clip_num);
  end

  // Sticky-at-max clip counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else if (i_sat_clr) begin
      sat_cnt_q <= '0;
    end else if (capture) begin
      sat_cnt_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  assign o_sat_cnt = sat_cnt_q;
`else
  logic unused_clip;
  assign unused_clip = ^clip;
`endif

endmodule

// File: tb/tb_vnu_msg_serializer.sv
// Self-checking bench for vnu_msg_serializer: table of bundles with expected
// saturated messages, scoreboard queues filled at capture and drained on output.
module tb_vnu_msg_serializer;
  import vnu_pkg::*;

  localparam int unsigned NE = VNU_N_EDGE;

  logic                     clk      = 1'b0;
  logic                     rst_n    = 1'b0;
  logic                     i_valid  = 1'b0;
  logic                     i_ready  = 1'b0;
  logic [0:NE][9:0]         i_data   = '0;
  logic [9:0]               i_vn_idx = '0;
  logic                     o_ready;
  logic                     o_valid;
  logic [5:0]               o_msg;
  logic [1:0]               o_edge;
  logic                     o_last;
  logic [9:0]               o_vn_idx;
  logic                     o_hd_valid;
  logic                     o_hd;
  logic [9:0]               o_app;
`ifdef VNU_SAT_CNT_EN
  logic                     i_sat_clr = 1'b0;
  logic [15:0]              o_sat_cnt;
`endif

  always #5 clk = ~clk;

  vnu_msg_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_vn_idx  (i_vn_idx),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_msg     (o_msg),
    .o_edge    (o_edge),
    .o_last    (o_last),
    .o_vn_idx  (o_vn_idx),
    .o_hd_valid(o_hd_valid),
    .o_hd      (o_hd),
    .o_app     (o_app)
`ifdef VNU_SAT_CNT_EN
    ,
    .i_sat_clr (i_sat_clr),
    .o_sat_cnt (o_sat_cnt)
`endif
  );

  typedef struct packed {
    logic [NE-1:0][9:0] ext;
    logic [9:0]         app;
    logic [NE-1:0][5:0] msg;
    logic               hd;
  } vec_t;

  typedef struct packed {
    logic [5:0] msg;
    logic [1:0] edge_n;
    logic       last;
    logic [9:0] idx;
  } beat_t;

  typedef struct packed {
    logic       hd;
    logic [9:0] app;
  } hd_t;

  vec_t  vecs [5];
  vec_t  cur;
  beat_t beat_q[$];
  hd_t   hd_q[$];

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int cap_cyc   = 0;
  int last_cyc  = 0;
  int valid_cnt = 0;
  bit captured  = 1'b0;
  bit rdy_chk   = 1'b0;

  function automatic vec_t mk(input logic [9:0] e0, input logic [9:0] e1,
                              input logic [9:0] e2, input logic [9:0] e3,
                              input logic [9:0] app,
                              input logic [5:0] m0, input logic [5:0] m1,
                              input logic [5:0] m2, input logic [5:0] m3,
                              input logic hd);
    vec_t v;
    v.ext[0] = e0; v.ext[1] = e1; v.ext[2] = e2; v.ext[3] = e3;
    v.msg[0] = m0; v.msg[1] = m1; v.msg[2] = m2; v.msg[3] = m3;
    v.app    = app;
    v.hd     = hd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sampled on the falling edge: record captures, check outputs against queues.
  task automatic monitor();
    beat_t b;
    hd_t   h;
    captured = 1'b0;
    if (rst_n && i_valid && o_ready) begin
      captured = 1'b1;
      cap_cyc  = cyc;
      for (int k = 0; k < NE; k++) begin
        b.msg    = cur.msg[k];
        b.edge_n = 2'(k);
        b.last   = (k == NE - 1);
        b.idx    = i_vn_idx;
        beat_q.push_back(b);
      end
      h.hd  = cur.hd;
      h.app = cur.app;
      hd_q.push_back(h);
    end
    if (o_valid) valid_cnt++;
    if (o_valid && i_ready) begin
      if (beat_q.size() == 0) begin
        chk("unexpected_beat", {31'd0, o_valid}, 32'd0);
      end else begin
        b = beat_q.pop_front();
        chk("msg", o_msg, b.msg);
        chk("edge", o_edge, b.edge_n);
        chk("last", o_last, b.last);
        chk("vn_idx", o_vn_idx, b.idx);
        if (rdy_chk) chk("ready_on_last", o_ready, b.last);
        if (b.last) last_cyc = cyc;
      end
    end
    if (o_hd_valid) begin
      if (hd_q.size() == 0) begin
        chk("unexpected_hd", {31'd0, o_hd_valid}, 32'd0);
      end else begin
        h = hd_q.pop_front();
        chk("hd", o_hd, h.hd);
        chk("app", o_app, h.app);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int v, input logic [9:0] vn);
    cur = vecs[v];
    for (int k = 0; k < NE; k++) i_data[k] = vecs[v].ext[k];
    i_data[NE] = vecs[v].app;
    i_vn_idx   = vn;
    i_valid    = 1'b1;
  endtask

  task automatic wait_capture();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!captured && n < 20);
    chk("capture_timeout", {31'd0, captured}, 32'd1);
  endtask

  task automatic chk_empty(input string name);
    chk(name, beat_q.size() + hd_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(10'h005, 10'h245, 10'h200, 10'h01F, 10'h3FF,
                 6'h05, 6'h3F, 6'h00, 6'h1F, 1'b1);
    vecs[1] = mk(10'h01F, 10'h020, 10'h1FF, 10'h21F, 10'h000,
                 6'h1F, 6'h1F, 6'h1F, 6'h3F, 1'b0);
    vecs[2] = mk(10'h220, 10'h3FF, 10'h000, 10'h001, 10'h1FF,
                 6'h3F, 6'h3F, 6'h00, 6'h01, 1'b0);
    vecs[3] = mk(10'h3E0, 10'h011, 10'h21E, 10'h100, 10'h200,
                 6'h3F, 6'h11, 6'h3E, 6'h1F, 1'b1);
    vecs[4] = mk(10'h3FF, 10'h3FF, 10'h1FF, 10'h020, 10'h155,
                 6'h3F, 6'h3F, 6'h1F, 6'h1F, 1'b0);

    // Reset state
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_msg", o_msg, 0);
    chk("rst_edge", o_edge, 0);
    chk("rst_last", o_last, 0);
    chk("rst_vn_idx", o_vn_idx, 0);
    chk("rst_hd_valid", o_hd_valid, 0);
    chk("rst_hd", o_hd, 0);
    chk("rst_app", o_app, 0);
    chk("rst_ready", o_ready, 1);
    rst_n = 1'b1;
    drain(2);

    // Single bundle, free-flowing output
    load(0, 10'd0);
    wait_capture();
    i_valid = 1'b0;
    chk("s1_first_valid", o_valid, 1);
    chk("s1_hd_pulse", o_hd_valid, 1);
    chk("s1_first_edge", o_edge, 0);
    drain(6);
    chk("s1_last_latency", last_cyc - cap_cyc, 4);
    chk("s1_app_held", o_app, 10'h3FF);
    chk("s1_hd_pulse_end", o_hd_valid, 0);
    chk_empty("s1_empty");

    // Back-to-back bundles, no bubbles
    rdy_chk   = 1'b1;
    valid_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      load(b + 1, 10'(b));
      wait_capture();
    end
    i_valid = 1'b0;
    drain(6);
    rdy_chk = 1'b0;
    chk("s2_valid_cycles", valid_cnt, 12);
    chk("s2_last_latency", last_cyc - cap_cyc, 4);
    chk_empty("s2_empty");

    // Backpressure on edge 1; upstream offers a bundle that must be ignored
    load(0, 10'h155);
    wait_capture();
    i_valid = 1'b0;
    step();
    i_ready = 1'b0;
    load(3, 10'h2AA);
    for (int i = 0; i < 3; i++) begin
      chk("s3_stall_edge", o_edge, 1);
      chk("s3_stall_valid", o_valid, 1);
      chk("s3_stall_ready", o_ready, 0);
      step();
      chk("s3_no_capture", {31'd0, captured}, 0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("s3_resume_edge", o_edge, 1);
    drain(5);
    chk("s3_last_latency", last_cyc - cap_cyc, 7);
    chk_empty("s3_empty");

    // Reset in the middle of a stream
    load(1, 10'h003);
    wait_capture();
    i_valid = 1'b0;
    step();
    step();
    chk("s4_pre_rst_edge", o_edge, 2);
    rst_n = 1'b0;
    #1;
    chk("s4_rst_valid", o_valid, 0);
    chk("s4_rst_ready", o_ready, 1);
    chk("s4_rst_edge", o_edge, 0);
    beat_q.delete();
    hd_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    load(2, 10'h004);
    wait_capture();
    i_valid = 1'b0;
    chk("s4_restart_edge", o_edge, 0);
    chk("s4_restart_idx", o_vn_idx, 10'h004);
    drain(6);
    chk_empty("s4_empty");

`ifdef VNU_SAT_CNT_EN
    // Saturation statistics counter
    i_sat_clr = 1'b1;
    step();
    i_sat_clr = 1'b0;
    chk("s6_clr0", o_sat_cnt, 0);
    load(0, 10'h010);
    wait_capture();
    i_valid = 1'b0;
    drain(5);
    chk("s6_one_clip", o_sat_cnt, 1);
    force dut.sat_cnt_q = 16'hFFFE;
    #1;
    release dut.sat_cnt_q;
    load(4, 10'h011);
    wait_capture();
    load(4, 10'h012);
    wait_capture();
    i_valid = 1'b0;
    drain(6);
    chk("s6_sticky", o_sat_cnt, 16'hFFFF);
    i_sat_clr = 1'b1;
    step();
    i_sat_clr = 1'b0;
    chk("s6_clr", o_sat_cnt, 0);
    chk_empty("s6_empty");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
